// File: rtl/mandel_job_scheduler_if.sv
// Engine job/result signals and the raster depth stream around mandel_job_scheduler.
// The scheduler takes the master modport; engines and the downstream packer take the slave.
interface mandel_job_scheduler_if #(
    parameter int NUM_ENGINES = 4,
    parameter int DEPTH_W     = 10
);
    logic [NUM_ENGINES-1:0]         eng_start;
    logic [10:0]                    eng_x;
    logic [10:0]                    eng_y;
    logic [NUM_ENGINES-1:0]         eng_done;
    logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth;
    logic                           pix_valid;
    logic                           pix_ready;
    logic [DEPTH_W-1:0]             pix_depth;
    logic                           pix_sof;
    logic                           pix_eol;

    modport master (
        output eng_start, eng_x, eng_y,
        input  eng_done, eng_depth,
        output pix_valid, pix_depth, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  eng_start, eng_x, eng_y,
        output eng_done, eng_depth,
        input  pix_valid, pix_depth, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/mandel_job_scheduler.sv
// Round-robin Mandelbrot job dispatcher with in-order result reassembly and frame-stable view shadows.
// Optional perf counters (stall_cycles, frame_cycles) are built when MANDEL_SCHED_PERF_EN is defined.
module mandel_job_scheduler #(
    parameter int NUM_ENGINES   = 4,
    parameter int SCREEN_WIDTH  = 960,
    parameter int SCREEN_HEIGHT = 720,
    parameter int DEPTH_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] cfg_max_iter,
    input  logic [31:0] cfg_zoom,
    input  logic [31:0] cfg_real_center,
    input  logic [31:0] cfg_imag_center,
    output logic [31:0] eng_max_iter,
    output logic [31:0] eng_zoom,
    output logic [31:0] eng_real_center,
    output logic [31:0] eng_imag_center,
    mandel_job_scheduler_if.master bus,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        protocol_err
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] frame_cycles
`endif
);
    localparam int          PTR_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [10:0] X_LAST = 11'(SCREEN_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic [31:0] max_iter;
        logic [31:0] zoom;
        logic [31:0] real_center;
        logic [31:0] imag_center;
    } view_t;

    typedef struct packed {
        logic [10:0] y;
        logic [10:0] x;
    } coord_t;

    function automatic coord_t next_coord(input coord_t c);
        coord_t n;
        n = c;
        if (c.x == X_LAST) begin
            n.x = '0;
            n.y = (c.y == Y_LAST) ? '0 : c.y + 11'd1;
        end else begin
            n.x = c.x + 11'd1;
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENGINES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_e                   state_q, state_d;
    view_t                    view_q, view_d, cfg_view;
    coord_t                   disp_q, disp_d, out_q, out_d;
    logic [PTR_W-1:0]         disp_ptr_q, disp_ptr_d, out_ptr_q, out_ptr_d;
    logic [NUM_ENGINES-1:0]   busy_q, busy_d, slot_full_q, slot_full_d;
    logic [DEPTH_W-1:0]       slot_q [NUM_ENGINES];
    logic [15:0]              frame_count_q, frame_count_d;
    logic                     protocol_err_q, protocol_err_d;
    logic                     latch;

    logic                     consume, eligible, dispatch, last_out, last_disp;
    logic [NUM_ENGINES-1:0]   start_vec, take_vec, done_ok, done_bad;

    assign cfg_view = {cfg_max_iter, cfg_zoom, cfg_real_center, cfg_imag_center};

    // A slot being drained this cycle counts as free, so a full pipeline never loses a dispatch slot.
    assign consume   = slot_full_q[out_ptr_q] & bus.pix_ready;
    assign eligible  = !busy_q[disp_ptr_q] &&
                       (!slot_full_q[disp_ptr_q] || (consume && (out_ptr_q == disp_ptr_q)));
    assign dispatch  = (state_q == RUN) && eligible;
    assign last_disp = dispatch && (disp_q.x == X_LAST) && (disp_q.y == Y_LAST);
    assign last_out  = consume && (out_q.x == X_LAST) && (out_q.y == Y_LAST);
    assign start_vec = dispatch ? (NUM_ENGINES'(1) << disp_ptr_q) : '0;
    assign take_vec  = consume ? (NUM_ENGINES'(1) << out_ptr_q) : '0;
    assign done_ok   = bus.eng_done & busy_q & ~slot_full_q;
    assign done_bad  = bus.eng_done & ~done_ok;

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can leave a latch behind.
        state_d        = state_q;
        view_d         = view_q;
        disp_d         = disp_q;
        disp_ptr_d     = disp_ptr_q;
        out_d          = out_q;
        out_ptr_d      = out_ptr_q;
        busy_d         = (busy_q & ~done_ok) | start_vec;
        slot_full_d    = (slot_full_q | done_ok) & ~take_vec;
        frame_count_d  = frame_count_q;
        protocol_err_d = protocol_err_q | (|done_bad);
        latch          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    latch   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_disp) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_out) begin
                    frame_count_d = frame_count_q + 16'd1;
                    if (enable) begin
                        latch   = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) view_d = cfg_view;
        if (dispatch) begin
            disp_d     = next_coord(disp_q);
            disp_ptr_d = next_ptr(disp_ptr_q);
        end
        if (consume) begin
            out_d     = next_coord(out_q);
            out_ptr_d = next_ptr(out_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= only, so every register sees pre-edge values of its peers.
        if (reset) begin
            state_q        <= IDLE;
            view_q         <= '0;
            disp_q         <= '0;
            disp_ptr_q     <= '0;
            out_q          <= '0;
            out_ptr_q      <= '0;
            busy_q         <= '0;
            slot_full_q    <= '0;
            frame_count_q  <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            view_q         <= view_d;
            disp_q         <= disp_d;
            disp_ptr_q     <= disp_ptr_d;
            out_q          <= out_d;
            out_ptr_q      <= out_ptr_d;
            busy_q         <= busy_d;
            slot_full_q    <= slot_full_d;
            frame_count_q  <= frame_count_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the result slots are reset despite being storage, because pix_depth reads them directly.
        if (reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (done_ok[i]) slot_q[i] <= bus.eng_depth[i*DEPTH_W +: DEPTH_W];
            end
        end
    end

    assign bus.eng_start = start_vec;
    assign bus.eng_x     = disp_q.x;
    assign bus.eng_y     = disp_q.y;
    assign bus.pix_valid = slot_full_q[out_ptr_q];
    assign bus.pix_depth = slot_q[out_ptr_q];
    assign bus.pix_sof   = slot_full_q[out_ptr_q] && (out_q.x == '0) && (out_q.y == '0);
    assign bus.pix_eol   = slot_full_q[out_ptr_q] && (out_q.x == X_LAST);

    assign eng_max_iter    = view_q.max_iter;
    assign eng_zoom        = view_q.zoom;
    assign eng_real_center = view_q.real_center;
    assign eng_imag_center = view_q.imag_center;
    assign busy            = (state_q != IDLE);
    assign frame_count     = frame_count_q;
    assign protocol_err    = protocol_err_q;

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] stall_q, run_cnt_q, frame_cyc_q;

    // run_cnt_q counts cycles since the latch; the accept cycle itself is added on capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q     <= '0;
            run_cnt_q   <= '0;
            frame_cyc_q <= '0;
        end else begin
            if (latch) begin
                stall_q   <= '0;
                run_cnt_q <= '0;
            end else begin
                if ((state_q == RUN) && !eligible) stall_q <= stall_q + 32'd1;
                if (state_q != IDLE) run_cnt_q <= run_cnt_q + 32'd1;
            end
            if (last_out) frame_cyc_q <= run_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign frame_cycles = frame_cyc_q;
`endif
endmodule

// File: doc/mandel_job_scheduler.md
Name: mandel_job_scheduler

Overview:
- Sequences a frame of Mandelbrot work across NUM_ENGINES iteration engines.
- Hands pixel coordinates to engines in strict round-robin raster order. Holds one result per engine and emits depths to the colour-map/packer stage in raster order with valid/ready.
- Shadows the AXI-Lite view parameters (MAX_ITER, ZOOM, centres) so they change only at frame boundaries.

Parameters:
- NUM_ENGINES, 4, number of engines; power of two, 1..16.
- SCREEN_WIDTH, 960, pixels per line.
- SCREEN_HEIGHT, 720, lines per frame.
- DEPTH_W, 10, engine depth result width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run frames continuously while high.
- cfg_max_iter, cfg_zoom, cfg_real_center, cfg_imag_center  in  32 each  live register-file values.
- eng_max_iter, eng_zoom, eng_real_center, eng_imag_center  out  32 each  frame-stable shadow copies fed to all engines.
- eng_start  out  NUM_ENGINES  one-hot, one-cycle job strobe.
- eng_x  out  11  job x; valid with eng_start.
- eng_y  out  11  job y; valid with eng_start.
- eng_done  in  NUM_ENGINES  one-cycle result strobe per engine.
- eng_depth  in  NUM_ENGINES*DEPTH_W  per-engine depth; slice i is valid with eng_done[i].
- pix_valid  out  1  output depth available.
- pix_ready  in  1  downstream accept.
- pix_depth  out  DEPTH_W  depth of current raster pixel.
- pix_sof  out  1  current pixel is (0,0).
- pix_eol  out  1  current pixel has x = SCREEN_WIDTH-1.
- busy  out  1  state != IDLE.
- frame_count  out  16  completed frames; wraps.
- protocol_err  out  1  sticky; set on eng_done[i] while engine i is not busy or slot i is full.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; dispatch/output coordinates (0,0); disp_ptr=out_ptr=0; all busy and slot_full bits cleared. Reset mid-frame abandons all jobs; late eng_done pulses after reset set protocol_err.
- States:
  - IDLE: if enable, latch cfg_* into eng_* and go to RUN.
  - RUN: dispatch; after the job at (W-1,H-1) issues, go to DRAIN.
  - DRAIN: no dispatch. When the last pixel is accepted: frame_count++. If enable, re-latch cfg and go to RUN at (0,0); else go to IDLE.
- Shadow cfg_* changes only in the latch cycle; never mid-frame.
- Dispatch, RUN only: engine e=disp_ptr is eligible when !busy[e] and (!slot_full[e] or slot e is consumed this cycle).
  - Eligible: eng_start[e]=1 with eng_x/eng_y = dispatch coords; set busy[e]; disp_ptr=(e+1) mod N; advance coords raster-wise (x wraps at W-1, y increments).
  - Not eligible: stall; never skip to another engine.
  - Order of jobs is therefore fixed: job k goes to engine k mod N.
- First eng_start occurs in the first RUN cycle, one cycle after enable is sampled in IDLE.
- Capture: eng_done[i] stores its depth slice in slot i; slot_full[i]=1; busy[i]=0.
- Output:
  - pix_valid = slot_full[out_ptr]; pix_depth = slot[out_ptr].
  - pix_sof/pix_eol are decoded from the output coords.
  - All are driven from registers only; no combinational path from pix_ready.
  - On pix_valid & pix_ready: clear slot_full[out_ptr]; out_ptr++ mod N; advance output coords.
  - pix_valid must hold stable with its data until accepted.
- Simultaneous events:
  - Capture into slot i and consume of slot j≠i in the same cycle are independent.
  - Consume of slot e and dispatch to engine e in the same cycle is allowed.
- Outstanding jobs never exceed NUM_ENGINES. With pix_ready held low, dispatch halts after at most N jobs.
- Arithmetic: coordinates are unsigned, 11-bit, compared against W-1 and H-1; frame_count wraps at 65535→0.

Optional Feature:
- Macro: MANDEL_SCHED_PERF_EN.
- Defined: adds outputs stall_cycles (32) and frame_cycles (32).
  - stall_cycles counts RUN cycles where the engine at disp_ptr is not eligible.
  - frame_cycles counts cycles from a cfg latch to last-pixel accept, and is captured at frame end.
  - Both reset to 0; stall_cycles clears at each cfg latch.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Setup: N=4, W=8, H=4, engine model returning depth=x+8y with latency per engine 40/30/20/10 (engine 0 slowest), pix_ready=1, enable pulsed for one frame.
  - Required: 32 outputs with depths 0..31 in order; pix_sof only on the first; pix_eol on every 8th; frame_count=1; returns to IDLE with busy=0.
- pix_ready low for 100 cycles from start -> exactly 4 eng_start pulses, then no further dispatch; after release, depths remain in order.
- Change cfg_zoom from 1 to 2 mid-frame with enable held -> eng_zoom stays 1 until the cycle after the last pixel of frame 0 is accepted, then 2; first eng_start of frame 1 carries (0,0).
- Assert reset while 3 jobs are outstanding -> all outputs 0 in the same cycle; subsequent eng_done[1] pulse sets protocol_err=1, which stays set.
- Double eng_done[2] without an intervening eng_start[2] -> protocol_err=1; output order unaffected.
- MANDEL_SCHED_PERF_EN with single-cycle engines, pix_ready=1 -> stall_cycles small and deterministic; frame_cycles ≥ 32 and matches the bench cycle count.
